// File: rtl/risc16_pkg.sv
// Shared encodings for the multi-cycle RISC16 controller: opcodes, ALU selects, FSM states.
// Pure constants and helpers; no timing or flow control of its own.
package risc16_pkg;

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_INV = 4'b0100;
    localparam logic [3:0] OP_LSL = 4'b0101;
    localparam logic [3:0] OP_LSR = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;

    localparam logic [2:0] ALU_ADDR  = 3'b000;
    localparam logic [2:0] ALU_CMP   = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_INV   = 3'b100;
    localparam logic [2:0] ALU_LSL   = 3'b101;
    localparam logic [2:0] ALU_LSR   = 3'b110;
    // AND/OR/SLT share one select; the datapath picks the function from IR[15:12]
    localparam logic [2:0] ALU_LOGIC = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    function automatic logic is_alu_class(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SLT);
    endfunction

    function automatic logic is_undefined(input logic [3:0] op);
        return (op == 4'b1010) || (op == 4'b1110) || (op == 4'b1111);
    endfunction

endpackage

// File: rtl/risc16_multicycle_sequencer_if.sv
// Controller <-> datapath/memory bundle: opcode and acks in, strobes and level controls out.
// Master is the sequencer; the slave side owns the memories and the register file.
interface risc16_multicycle_sequencer_if;
    logic [3:0] opcode;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       jump;
    logic       beq;
    logic       bne;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_op;
    logic       illegal_op;

    modport master (
        input  opcode, imem_ack, dmem_ack,
        output imem_req, ir_write, pc_write, jump, beq, bne, reg_dst, alu_src,
               mem_to_reg, reg_write, mem_read, mem_write, alu_op, illegal_op
    );

    modport slave (
        output opcode, imem_ack, dmem_ack,
        input  imem_req, ir_write, pc_write, jump, beq, bne, reg_dst, alu_src,
               mem_to_reg, reg_write, mem_read, mem_write, alu_op, illegal_op
    );
endinterface

// File: rtl/risc16_ctrl_decode.sv
// Level datapath controls from the latched opcode; combinational, zero latency.
// Outputs held for EXEC..WB and forced low elsewhere; no flow control.
module risc16_ctrl_decode
    import risc16_pkg::*;
(
    input  logic [3:0] op_q,
    input  state_e     state,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic       reg_dst,
    output logic       mem_to_reg
);

    always_comb begin
        alu_op     = ALU_ADDR;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        if (state inside {ST_EXEC, ST_MEM, ST_WB}) begin
            reg_dst = is_alu_class(op_q);
            case (op_q)
                OP_LD: begin
                    alu_src    = 1'b1;
                    mem_to_reg = 1'b1;
                end
                OP_ST:                  alu_src = 1'b1;
                OP_BEQ, OP_BNE:         alu_op  = ALU_CMP;
                OP_ADD:                 alu_op  = ALU_ADD;
                OP_SUB:                 alu_op  = ALU_SUB;
                OP_INV:                 alu_op  = ALU_INV;
                OP_LSL:                 alu_op  = ALU_LSL;
                OP_LSR:                 alu_op  = ALU_LSR;
                OP_AND, OP_OR, OP_SLT:  alu_op  = ALU_LOGIC;
                default:                alu_op  = ALU_ADDR;
            endcase
        end
    end

endmodule

// File: rtl/risc16_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller; 2 (JMP) to 5 (LD) cycles plus ack waits.
// Memory requests are held level until the matching ack; run is only sampled in IDLE and at instruction end.
module risc16_multicycle_sequencer
    import risc16_pkg::*;
#(
    parameter int unsigned RESET_RUN = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    output logic [2:0]                    state,
    risc16_multicycle_sequencer_if.master bus
);

    localparam state_e RST_STATE = (RESET_RUN != 0) ? ST_FETCH : ST_IDLE;

    state_e     state_q, state_d;
    state_e     end_state;
    logic [3:0] op_q, op_d;

    logic imem_req, ir_write, pc_write, jump, beq, bne;
    logic reg_write, mem_read, mem_write, illegal_op;

    assign end_state = run ? ST_FETCH : ST_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        jump       = 1'b0;
        beq        = 1'b0;
        bne        = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            // op_q is not loaded yet, so DECODE steers from the live IR opcode
            ST_DECODE: begin
                op_d = bus.opcode;
                if (bus.opcode == OP_JMP) begin
                    jump    = 1'b1;
                    state_d = end_state;
                end else if (is_undefined(bus.opcode)) begin
                    illegal_op = 1'b1;
                    state_d    = end_state;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_q == OP_BEQ) begin
                    beq     = 1'b1;
                    state_d = end_state;
                end else if (op_q == OP_BNE) begin
                    bne     = 1'b1;
                    state_d = end_state;
                end else if ((op_q == OP_LD) || (op_q == OP_ST)) begin
                    state_d = ST_MEM;
                end else if (is_alu_class(op_q)) begin
                    state_d = ST_WB;
                end else begin
                    state_d = end_state;
                end
            end
            ST_MEM: begin
                mem_read  = (op_q == OP_LD);
                mem_write = (op_q != OP_LD);
                if (bus.dmem_ack) state_d = (op_q == OP_LD) ? ST_WB : end_state;
            end
            ST_WB: begin
                reg_write = 1'b1;
                state_d   = end_state;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    risc16_ctrl_decode u_decode (
        .op_q       (op_q),
        .state      (state_q),
        .alu_op     (bus.alu_op),
        .alu_src    (bus.alu_src),
        .reg_dst    (bus.reg_dst),
        .mem_to_reg (bus.mem_to_reg)
    );

    assign state          = state_q;
    assign bus.imem_req   = imem_req;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.jump       = jump;
    assign bus.beq        = beq;
    assign bus.bne        = bne;
    assign bus.reg_write  = reg_write;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.illegal_op = illegal_op;

endmodule

// File: tb/tb_risc16_multicycle_sequencer.sv
// Directed per-cycle vectors for the RISC16 sequencer; expected outputs queued, checked by a negedge monitor.
module tb_risc16_multicycle_sequencer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       run   = 1'b0;
    logic [2:0] state;

    risc16_multicycle_sequencer_if bus();

    risc16_multicycle_sequencer #(.RESET_RUN(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .state (state),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Flag order matches the observed vector below: imem_req down to illegal_op
    localparam logic [12:0] F_IREQ = 13'h1000;
    localparam logic [12:0] F_IRW  = 13'h0800;
    localparam logic [12:0] F_PCW  = 13'h0400;
    localparam logic [12:0] F_JMP  = 13'h0200;
    localparam logic [12:0] F_BEQ  = 13'h0100;
    localparam logic [12:0] F_BNE  = 13'h0080;
    localparam logic [12:0] F_RDST = 13'h0040;
    localparam logic [12:0] F_ASRC = 13'h0020;
    localparam logic [12:0] F_M2R  = 13'h0010;
    localparam logic [12:0] F_RWR  = 13'h0008;
    localparam logic [12:0] F_MRD  = 13'h0004;
    localparam logic [12:0] F_MWR  = 13'h0002;
    localparam logic [12:0] F_ILL  = 13'h0001;
    localparam logic [12:0] F_FA   = F_IREQ | F_IRW | F_PCW;
    localparam logic [12:0] F_LDL  = F_ASRC | F_M2R;

    typedef struct {
        string       name;
        logic [18:0] vec;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [18:0] mon_got;
    int          checks = 0;
    int          errors = 0;

    task automatic cyc(input string nm, input logic rst, input logic r, input logic [3:0] op,
                       input logic ia, input logic da, input logic [2:0] st,
                       input logic [2:0] aop, input logic [12:0] fl);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rst;
        run          = r;
        bus.opcode   = op;
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        e.name = nm;
        e.vec  = {st, aop, fl};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {state, bus.alu_op, bus.imem_req, bus.ir_write, bus.pc_write, bus.jump,
                       bus.beq, bus.bne, bus.reg_dst, bus.alu_src, bus.mem_to_reg,
                       bus.reg_write, bus.mem_read, bus.mem_write, bus.illegal_op};
            checks++;
            if (mon_got !== mon_e.vec) begin
                errors++;
                $display("FAIL %s got state=%0d alu_op=%b flags=%b want state=%0d alu_op=%b flags=%b",
                         mon_e.name, mon_got[18:16], mon_got[15:13], mon_got[12:0],
                         mon_e.vec[18:16], mon_e.vec[15:13], mon_e.vec[12:0]);
            end
        end
    end

    initial begin
        bus.opcode   = 4'h0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;

        //  name             rst run op    ia da st    aop     flags
        cyc("reset0",         0, 0, 4'h0, 0, 0, 3'd0, 3'b000, 13'h0);
        cyc("reset_run_ack",  0, 1, 4'h2, 1, 0, 3'd0, 3'b000, 13'h0);
        cyc("idle_run0",      1, 0, 4'h2, 0, 0, 3'd0, 3'b000, 13'h0);
        cyc("idle_go",        1, 1, 4'h2, 0, 0, 3'd0, 3'b000, 13'h0);
        // ADD, zero-wait fetch
        cyc("add_fetch",      1, 1, 4'h2, 1, 0, 3'd1, 3'b000, F_FA);
        cyc("add_decode",     1, 1, 4'h2, 0, 0, 3'd2, 3'b000, 13'h0);
        cyc("add_exec",       1, 1, 4'h2, 0, 0, 3'd3, 3'b010, F_RDST);
        cyc("add_wb",         1, 1, 4'h2, 0, 0, 3'd5, 3'b010, F_RDST | F_RWR);
        // AND, one fetch wait with a stray dmem_ack
        cyc("and_fetch_wait", 1, 1, 4'h7, 0, 1, 3'd1, 3'b000, F_IREQ);
        cyc("and_fetch",      1, 1, 4'h7, 1, 0, 3'd1, 3'b000, F_FA);
        cyc("and_decode",     1, 1, 4'h7, 0, 0, 3'd2, 3'b000, 13'h0);
        cyc("and_exec",       1, 1, 4'h7, 0, 0, 3'd3, 3'b111, F_RDST);
        cyc("and_wb",         1, 1, 4'h7, 0, 0, 3'd5, 3'b111, F_RDST | F_RWR);
        // LD with dmem_ack three cycles late: 8 cycles total
        cyc("ld_fetch",       1, 1, 4'h0, 1, 0, 3'd1, 3'b000, F_FA);
        cyc("ld_decode",      1, 1, 4'h0, 0, 0, 3'd2, 3'b000, 13'h0);
        cyc("ld_exec",        1, 1, 4'h0, 0, 0, 3'd3, 3'b000, F_LDL);
        cyc("ld_mem_w0",      1, 1, 4'h0, 0, 0, 3'd4, 3'b000, F_LDL | F_MRD);
        cyc("ld_mem_w1",      1, 1, 4'h0, 0, 0, 3'd4, 3'b000, F_LDL | F_MRD);
        cyc("ld_mem_w2",      1, 1, 4'h0, 0, 0, 3'd4, 3'b000, F_LDL | F_MRD);
        cyc("ld_mem_ack",     1, 1, 4'h0, 0, 1, 3'd4, 3'b000, F_LDL | F_MRD);
        cyc("ld_wb",          1, 1, 4'h0, 0, 0, 3'd5, 3'b000, F_LDL | F_RWR);
        // BEQ then JMP
        cyc("beq_fetch",      1, 1, 4'hB, 1, 0, 3'd1, 3'b000, F_FA);
        cyc("beq_decode",     1, 1, 4'hB, 0, 0, 3'd2, 3'b000, 13'h0);
        cyc("beq_exec",       1, 1, 4'hB, 0, 0, 3'd3, 3'b001, F_BEQ);
        cyc("jmp_fetch",      1, 1, 4'hD, 1, 0, 3'd1, 3'b000, F_FA);
        cyc("jmp_decode",     1, 1, 4'hD, 0, 0, 3'd2, 3'b000, F_JMP);
        // Undefined opcode 1110, fetched in JMP's cycle 3
        cyc("ill_fetch",      1, 1, 4'hE, 1, 0, 3'd1, 3'b000, F_FA);
        cyc("ill_decode",     1, 1, 4'hE, 0, 0, 3'd2, 3'b000, F_ILL);
        // BNE
        cyc("bne_fetch",      1, 1, 4'hC, 1, 0, 3'd1, 3'b000, F_FA);
        cyc("bne_decode",     1, 1, 4'hC, 0, 0, 3'd2, 3'b000, 13'h0);
        cyc("bne_exec",       1, 1, 4'hC, 0, 0, 3'd3, 3'b001, F_BNE);
        // ST aborted by reset while waiting in MEM; stray imem_ack in MEM ignored
        cyc("st_fetch",       1, 1, 4'h1, 1, 0, 3'd1, 3'b000, F_FA);
        cyc("st_decode",      1, 1, 4'h1, 0, 0, 3'd2, 3'b000, 13'h0);
        cyc("st_exec",        1, 1, 4'h1, 0, 0, 3'd3, 3'b000, F_ASRC);
        cyc("st_mem_iack",    1, 1, 4'h1, 1, 0, 3'd4, 3'b000, F_ASRC | F_MWR);
        cyc("st_async_rst",   0, 1, 4'h1, 0, 0, 3'd0, 3'b000, 13'h0);
        cyc("rst_hold",       0, 1, 4'h1, 0, 0, 3'd0, 3'b000, 13'h0);
        cyc("post_rst_idle",  1, 0, 4'h0, 0, 0, 3'd0, 3'b000, 13'h0);
        // LD with run dropped in EXEC: completes, then IDLE ignores imem_ack
        cyc("ld2_go",         1, 1, 4'h0, 0, 0, 3'd0, 3'b000, 13'h0);
        cyc("ld2_fetch",      1, 1, 4'h0, 1, 0, 3'd1, 3'b000, F_FA);
        cyc("ld2_decode",     1, 1, 4'h0, 0, 0, 3'd2, 3'b000, 13'h0);
        cyc("ld2_exec_run0",  1, 0, 4'h0, 0, 0, 3'd3, 3'b000, F_LDL);
        cyc("ld2_mem",        1, 0, 4'h0, 0, 1, 3'd4, 3'b000, F_LDL | F_MRD);
        cyc("ld2_wb",         1, 0, 4'h0, 0, 0, 3'd5, 3'b000, F_LDL | F_RWR);
        cyc("idle_stray_ack", 1, 0, 4'h0, 1, 0, 3'd0, 3'b000, 13'h0);
        cyc("idle_stays",     1, 0, 4'h0, 0, 0, 3'd0, 3'b000, 13'h0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
